// File: rtl/count_seq_monitor.sv
// Receive-side checker for a free-running binary counter stream: locks onto
// the incrementing sequence, then flags/counts mismatches and counts wraps.
module count_seq_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int STAT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              clr_stats,
  output logic              locked,
  output logic              err_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  last_count
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [RUN_W-1:0]  LOCK_V   = RUN_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] UNLOCK_V = MISS_W'(UNLOCK_CNT);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    exp_q, exp_d;
  logic [WIDTH-1:0]    last_q, last_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic [STAT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [STAT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                match;
  logic                err_inc;
  logic                wrap_inc;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    last_d      = last_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    wrap_inc    = 1'b0;
    match       = (count_in == exp_q);

    if (sample_en) begin
      last_d = count_in;
      case (state_q)
        HUNT: begin
          exp_d   = count_in + WIDTH'(1);
          run_d   = RUN_W'(1);
          state_d = SYNC;
        end
        SYNC: begin
          if (match) begin
            exp_d = exp_q + WIDTH'(1);
            run_d = run_q + RUN_W'(1);
            if (run_d == LOCK_V) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            exp_d = count_in + WIDTH'(1);
            run_d = RUN_W'(1);
          end
        end
        LOCKED: begin
          // Flywheel: expectation advances on a miss so a single glitch is absorbed.
          exp_d = exp_q + WIDTH'(1);
          if (match) begin
            miss_d   = '0;
            wrap_inc = (count_in == '0);
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_d      = miss_q + MISS_W'(1);
            if (miss_d == UNLOCK_V) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCKED);

    if (clr_stats)                             err_cnt_d = '0;
    else if (err_inc && err_cnt_q != STAT_MAX) err_cnt_d = err_cnt_q + STAT_W'(1);
    else                                       err_cnt_d = err_cnt_q;

    if (clr_stats)                               wrap_cnt_d = '0;
    else if (wrap_inc && wrap_cnt_q != STAT_MAX) wrap_cnt_d = wrap_cnt_q + STAT_W'(1);
    else                                         wrap_cnt_d = wrap_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      last_q      <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      last_q      <= last_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_cnt_q;
  assign wrap_count = wrap_cnt_q;
  assign last_count = last_q;

endmodule
